cordic_seq: RTL and testbench
=============================

# cordic_seq

Iteration sequencer for the CORDIC angle engine. Accepts a start request, loads the x/y/z datapath registers, then steps the arctangent ROM address and shift amount through N_ITER micro-rotations, driving the per-iteration rotation direction. Sits between the requesting logic and the CORDIC datapath/ROM pair; the ROM is read asynchronously, so `addr` is consumed in the same cycle it is driven.

## Interface
- `ADDR_WIDTH`, 4: width of ROM address / iteration index.
- `N_ITER`, 16: iterations per operation; legal range 1..2^ADDR_WIDTH.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: operation request; accepted only in IDLE.
- `abort` in 1: cancel current operation.
- `mode` in 1: present only with `CORDIC_VECTOR_MODE_EN`; 0 = rotation, 1 = vectoring; sampled on accepted `start`.
- `z_sign` in 1: sign bit of the datapath z register (1 = negative).
- `y_sign` in 1: sign bit of the datapath y register (1 = negative).
- `ld` out 1: load x0/y0/z0 into datapath.
- `step_en` out 1: datapath performs one micro-rotation this cycle.
- `addr` out ADDR_WIDTH: ROM address and shift amount for current iteration.
- `dir` out 1: 1 = add (rotate positive), 0 = subtract.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, ITER, DONE.
- IDLE: `start`=1 and `abort`=0 -> LOAD; otherwise stay.
- LOAD: `ld`=1 for exactly one cycle; `addr` cleared to 0; -> ITER.
- ITER: `step_en`=1 each cycle; `addr` increments by 1 per cycle; when `addr`==N_ITER-1 -> DONE, else stay.
- DONE: `done`=1 one cycle; -> IDLE. Next `start` may be accepted in the following IDLE cycle.
- `busy`=1 in LOAD, ITER, DONE; 0 in IDLE.
- `start` while busy: ignored, not queued.
- `abort`=1 in any state: next state IDLE, `addr` <= 0, no `done` pulse; `abort` beats `start` in the same cycle.
- `addr` holds 0 outside ITER; never wraps past N_ITER-1 (counter compare, not overflow, terminates).
- `dir` is combinational from the sign inputs: rotation mode `dir` = ~`z_sign`; vectoring mode `dir` = `y_sign`. Meaningful only while `step_en`=1; driven 0 otherwise.
- `ld`, `step_en`, `done`, `busy` are decoded from registered state (glitch-free, no input-to-output path).

## Timing
- Reset: state IDLE, `addr`=0, `ld`=0, `step_en`=0, `done`=0, `busy`=0, `dir`=0, mode register=0. `rst` mid-operation discards it, no `done`.
- `start` sampled at edge t -> `ld` in cycle t+1 -> `step_en` cycles t+2..t+N_ITER+1 with `addr`=0..N_ITER-1 -> `done` in cycle t+N_ITER+2.
- Total latency start-to-done N_ITER+2 cycles; back-to-back throughput one operation per N_ITER+3 cycles.
- `rst` has priority over `abort`, which has priority over `start`.

## Configuration
- `CORDIC_VECTOR_MODE_EN` defined: `mode` port exists, registered on accepted `start`, selects `dir` source per Operation.
- Not defined: no `mode` port, no mode register; rotation mode only, `dir` = ~`z_sign`.

## Test plan
- Basic (N_ITER=16): `start` pulse at cycle 10 -> `ld`=1 at 11, `step_en`=1 cycles 12..27 with `addr` 0..15, `done`=1 at 28 only, `busy` high 11..28.
- Direction: rotation, hold `z_sign`=0 for addr 0..7 then 1 -> `dir`=1 for addr 0..7, 0 for addr 8..15; with macro and `mode`=1, `y_sign`=1 -> `dir`=1.
- Start while busy: second `start` at `addr`=5 -> ignored, single `done` at expected cycle, no extra `ld`.
- Abort: `abort` at `addr`=5 -> next cycle IDLE, `busy`=0, `addr`=0, no `done`; `start` and `abort` together in IDLE -> stays IDLE.
- Reset mid-op: `rst`=1 at `addr`=9 -> all outputs at reset values next cycle; fresh `start` afterwards completes in 18 cycles.
- Edge config N_ITER=1: `start` at t -> `ld` t+1, one `step_en` with `addr`=0 at t+2, `done` at t+3.

Source files
------------

// File: rtl/cordic_seq.sv
// CORDIC iteration sequencer: load, N_ITER micro-rotation steps, done pulse.
// Optional vectoring-mode support is enabled with CORDIC_VECTOR_MODE_EN.
module cordic_seq #(
  parameter int ADDR_WIDTH = 4,
  parameter int N_ITER     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
`ifdef CORDIC_VECTOR_MODE_EN
  input  logic                  mode,
`endif
  input  logic                  z_sign,
  input  logic                  y_sign,
  output logic                  ld,
  output logic                  step_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  dir,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_ITER - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    ld_q, step_en_q, busy_q, done_q;

`ifdef CORDIC_VECTOR_MODE_EN
  logic mode_q, mode_d;
`else
  logic y_sign_unused;
  assign y_sign_unused = y_sign;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
`ifdef CORDIC_VECTOR_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
`ifdef CORDIC_VECTOR_MODE_EN
          mode_d  = mode;
`endif
        end
      end
      LOAD: begin
        state_d = ITER;
        addr_d  = '0;
      end
      ITER: begin
        // Terminate on compare so addr never runs past the last iteration.
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      addr_d  = '0;
`ifdef CORDIC_VECTOR_MODE_EN
      mode_d  = mode_q;
`endif
    end
  end

  // Status outputs are registered alongside the state so they never see input glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      ld_q      <= 1'b0;
      step_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CORDIC_VECTOR_MODE_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ld_q      <= (state_d == LOAD);
      step_en_q <= (state_d == ITER);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
`ifdef CORDIC_VECTOR_MODE_EN
      mode_q    <= mode_d;
`endif
    end
  end

  assign ld      = ld_q;
  assign step_en = step_en_q;
  assign addr    = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef CORDIC_VECTOR_MODE_EN
  assign dir = step_en_q & (mode_q ? y_sign : ~z_sign);
`else
  assign dir = step_en_q & ~z_sign;
`endif

endmodule

// File: tb/tb_cordic_seq.sv
// Directed bench for cordic_seq: a 16-iteration instance and a 1-iteration instance.
module tb_cordic_seq;

  logic       clk = 1'b0;
  logic       rst, start, abort, mode, z_sign, y_sign;
  logic       ld, step_en, dir, busy, done;
  logic [3:0] addr;

  logic       start1;
  logic       ld1, step_en1, dir1, busy1, done1;
  logic [3:0] addr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_seq #(.ADDR_WIDTH(4), .N_ITER(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef CORDIC_VECTOR_MODE_EN
    .mode(mode),
`endif
    .z_sign(z_sign), .y_sign(y_sign),
    .ld(ld), .step_en(step_en), .addr(addr), .dir(dir), .busy(busy), .done(done)
  );

  cordic_seq #(.ADDR_WIDTH(4), .N_ITER(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
`ifdef CORDIC_VECTOR_MODE_EN
    .mode(1'b0),
`endif
    .z_sign(1'b0), .y_sign(1'b0),
    .ld(ld1), .step_en(step_en1), .addr(addr1), .dir(dir1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ld"}, ld, 0);
    chk({tag, "_step_en"}, step_en, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dir"}, dir, 0);
  endtask

  // One full rotation-mode operation; optionally pulses start again at addr 5.
  task automatic run_op(input string tag, input bit extra_start);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_ld"}, ld, 1);
    chk({tag, "_busy_load"}, busy, 1);
    chk({tag, "_step_load"}, step_en, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      z_sign = (i >= 8);
      start  = extra_start && (i == 5);
      #1;
      chk({tag, "_step_en"}, step_en, 1);
      chk({tag, "_addr"}, addr, i);
      chk({tag, "_dir"}, dir, (i < 8) ? 1 : 0);
      chk({tag, "_ld_iter"}, ld, 0);
      chk({tag, "_done_iter"}, done, 0);
      chk({tag, "_busy_iter"}, busy, 1);
    end
    start  = 1'b0;
    z_sign = 1'b0;
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_step_done"}, step_en, 0);
    chk({tag, "_addr_done"}, addr, 0);
    tick();
    chk_idle({tag, "_after"});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    z_sign = 1'b0; y_sign = 1'b0; start1 = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_busy1", busy1, 0);
    rst = 1'b0;
    tick();
    chk_idle("idle");

    run_op("basic", 1'b0);
    $display("txn basic op complete");

    run_op("busy_start", 1'b1);
    tick();
    chk("busy_start_no_ld", ld, 0);
    chk("busy_start_idle", busy, 0);
    $display("txn start-while-busy op complete");

`ifdef CORDIC_VECTOR_MODE_EN
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    tick();
    y_sign = 1'b1; z_sign = 1'b1;
    #1;
    chk("vec_dir_y1", dir, 1);
    y_sign = 1'b0; z_sign = 1'b0;
    #1;
    chk("vec_dir_y0", dir, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("vec_abort");
    $display("txn vectoring dir checked");
`endif

    // Abort at addr 5
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_pre_addr", addr, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort");
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("abort_no_done", done, 0);
      chk("abort_stay_idle", busy, 0);
    end
    $display("txn abort at addr 5 complete");

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_idle("start_abort");
    tick();
    chk_idle("start_abort2");
    $display("txn start+abort stays idle");

    // Reset at addr 9
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_pre_addr", addr, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("midrst");
    tick();
    chk("midrst_no_done", done, 0);
    run_op("post_rst", 1'b0);
    $display("txn reset mid-op and fresh op complete");

    // N_ITER=1 instance
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("n1_ld", ld1, 1);
    chk("n1_busy", busy1, 1);
    tick();
    chk("n1_step", step_en1, 1);
    chk("n1_addr", addr1, 0);
    chk("n1_dir", dir1, 1);
    chk("n1_done_early", done1, 0);
    tick();
    chk("n1_done", done1, 1);
    chk("n1_step_off", step_en1, 0);
    tick();
    chk("n1_idle_busy", busy1, 0);
    chk("n1_idle_done", done1, 0);
    chk("n1_idle_addr", addr1, 0);
    $display("txn N_ITER=1 op complete");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
